// File: rtl/main_control_fsm.sv
// Multicycle main controller: sequences fetch/decode/execute/memory/writeback and
// drives the ALUOp, datapath selects and write enables from the current state.
module main_control_fsm #(
  parameter int OPCODE_W = 7,
  parameter int ALUOP_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                Zero,
  input  logic                mem_ready,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ResultSrc,
  output logic                AdrSrc,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic                instr_done,
  output logic                illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LW    = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ITYPE = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 7'b1101111;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  state_t state_r;
  state_t state_next_s;

  // State register: async clear lands in FETCH so no access continues past reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; unused encodings recover to FETCH.
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) begin
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW:    state_next_s = S_MEMADR;
          OP_SW:    state_next_s = S_MEMADR;
          OP_RTYPE: state_next_s = S_EXECR;
          OP_ITYPE: state_next_s = S_EXECI;
          OP_BEQ:   state_next_s = S_BEQ;
          OP_JAL:   state_next_s = S_JAL;
          default:  state_next_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_SW) begin
          state_next_s = S_MEMWRITE;
        end else begin
          state_next_s = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        if (mem_ready) begin
          state_next_s = S_MEMWB;
        end else begin
          state_next_s = S_MEMREAD;
        end
      end
      S_MEMWRITE: begin
        if (mem_ready) begin
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_MEMWRITE;
        end
      end
      S_EXECR:  state_next_s = S_ALUWB;
      S_EXECI:  state_next_s = S_ALUWB;
      S_JAL:    state_next_s = S_ALUWB;
      S_MEMWB:  state_next_s = S_FETCH;
      S_ALUWB:  state_next_s = S_FETCH;
      S_BEQ:    state_next_s = S_FETCH;
      default:  state_next_s = S_FETCH;
    endcase
  end

  // Output decode from the state register; handshake/flag qualifiers act in the same
  // cycle, and everything is forced low while rst_n is asserted.
  always_comb begin
    ALUOp      = ALUOP_ADD;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ResultSrc  = RES_ALUOUT;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      case (state_r)
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: illegal = 1'b0;
            default:                                          illegal = 1'b1;
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMREAD: begin
          AdrSrc = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc  = RES_MEM;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc     = 1'b1;
          MemWrite   = 1'b1;
          instr_done = mem_ready;
        end
        S_EXECR: begin
          ALUOp   = ALUOP_FUNCT;
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_RS2;
        end
        S_EXECI: begin
          ALUOp   = ALUOP_FUNCT;
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
        end
        S_ALUWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_JAL: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
        end
        S_BEQ: begin
          ALUOp      = ALUOP_SUB;
          ALUSrcA    = SRCA_RS1;
          ALUSrcB    = SRCB_RS2;
          PCWrite    = Zero;
          instr_done = 1'b1;
        end
        default: begin
          // FETCH and any unused encoding
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALU;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
      endcase
    end else begin
      ALUOp      = ALUOP_ADD;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RS2;
      ResultSrc  = RES_ALUOUT;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: walks each instruction class cycle by cycle
// and compares the packed control outputs against hand-written per-state vectors.
module tb_main_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       Zero;
  logic       mem_ready;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       instr_done;
  logic       illegal;
  logic [14:0] out_s;

  int checks_r;
  int failures_r;

  main_control_fsm #(.OPCODE_W(7), .ALUOP_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .Zero(Zero), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .instr_done(instr_done), .illegal(illegal)
  );

  // {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, instr_done, illegal}
  assign out_s = {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite,
                  RegWrite, MemWrite, instr_done, illegal};

  localparam logic [14:0] E_RST  = 15'd0;
  localparam logic [14:0] E_F1   = {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [14:0] E_F0   = {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [14:0] E_D    = {2'b00, 2'b01, 2'b01, 2'b00, 7'b0000000};
  localparam logic [14:0] E_DILL = {2'b00, 2'b01, 2'b01, 2'b00, 7'b0000001};
  localparam logic [14:0] E_MA   = {2'b00, 2'b10, 2'b01, 2'b00, 7'b0000000};
  localparam logic [14:0] E_MR   = {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 6'b000000};
  localparam logic [14:0] E_MWB  = {2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [14:0] E_MW0  = {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [14:0] E_MW1  = {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [14:0] E_XR   = {2'b10, 2'b10, 2'b00, 2'b00, 7'b0000000};
  localparam logic [14:0] E_XI   = {2'b10, 2'b10, 2'b01, 2'b00, 7'b0000000};
  localparam logic [14:0] E_AWB  = {2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [14:0] E_JAL  = {2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [14:0] E_BQ1  = {2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [14:0] E_BQ0  = {2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    checks_r = checks_r + 1;
    if (obs !== exp) begin
      failures_r = failures_r + 1;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs already set: compare, then advance one cycle.
  task automatic cyc(input string tag, input logic [14:0] exp);
    #2;
    check_val(tag, out_s, exp);
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus sequence.
  initial begin
    checks_r   = 0;
    failures_r = 0;
    rst_n      = 1'b0;
    opcode     = 7'b0000000;
    Zero       = 1'b0;
    mem_ready  = 1'b1;
    #2;
    check_val("rst_hold", out_s, E_RST);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_edge", out_s, E_RST);
    rst_n = 1'b1;

    // FETCH stall, then lw with a two-cycle memory wait and a ready lw
    mem_ready = 1'b0; opcode = 7'b0000011;
    cyc("f_stall", E_F0);
    mem_ready = 1'b1;
    cyc("lw_f", E_F1);
    cyc("lw_d", E_D);
    cyc("lw_ma", E_MA);
    cyc("lw_mr", E_MR);
    cyc("lw_mwb", E_MWB);
    cyc("lw2_f", E_F1);
    cyc("lw2_d", E_D);
    cyc("lw2_ma", E_MA);
    mem_ready = 1'b0;
    cyc("lw2_mr_w0", E_MR);
    cyc("lw2_mr_w1", E_MR);
    mem_ready = 1'b1;
    cyc("lw2_mr", E_MR);
    cyc("lw2_mwb", E_MWB);

    // addi
    opcode = 7'b0010011;
    cyc("addi_f", E_F1);
    cyc("addi_d", E_D);
    cyc("addi_x", E_XI);
    cyc("addi_wb", E_AWB);

    // R-type
    opcode = 7'b0110011;
    cyc("r_f", E_F1);
    cyc("r_d", E_D);
    cyc("r_x", E_XR);
    cyc("r_wb", E_AWB);

    // beq taken then not taken
    opcode = 7'b1100011; Zero = 1'b1;
    cyc("beq1_f", E_F1);
    cyc("beq1_d", E_D);
    cyc("beq1_b", E_BQ1);
    Zero = 1'b0;
    cyc("beq0_f", E_F1);
    cyc("beq0_d", E_D);
    cyc("beq0_b", E_BQ0);

    // jal
    opcode = 7'b1101111;
    cyc("jal_f", E_F1);
    cyc("jal_d", E_D);
    cyc("jal_j", E_JAL);
    cyc("jal_wb", E_AWB);

    // sw with three not-ready cycles in MEMWRITE
    opcode = 7'b0100011;
    cyc("sw_f", E_F1);
    cyc("sw_d", E_D);
    cyc("sw_ma", E_MA);
    mem_ready = 1'b0;
    cyc("sw_w0", E_MW0);
    cyc("sw_w1", E_MW0);
    cyc("sw_w2", E_MW0);
    mem_ready = 1'b1;
    cyc("sw_w3", E_MW1);

    // unsupported opcode
    opcode = 7'b1110011;
    cyc("ill_f", E_F1);
    cyc("ill_d", E_DILL);
    cyc("ill_back_f", E_F1);
    cyc("ill_back_d", E_DILL);

    // reset asserted mid-MEMWRITE
    opcode = 7'b0100011;
    cyc("rsw_f", E_F1);
    cyc("rsw_d", E_D);
    cyc("rsw_ma", E_MA);
    mem_ready = 1'b0;
    cyc("rsw_w", E_MW0);
    rst_n = 1'b0;
    #1;
    check_val("rsw_rst", out_s, E_RST);
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    opcode = 7'b0110011;
    rst_n = 1'b1;
    cyc("rsw_f_after", E_F1);
    cyc("rsw_d_after", E_D);
    cyc("rsw_x_after", E_XR);
    cyc("rsw_wb_after", E_AWB);

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
